// File: rtl/mem_wb_stage_reg.sv
// MEM/WB pipeline register with writeback data formatting.
// Holds WB control and data, drives the register-file write port.
module mem_wb_stage_reg #(
  parameter int CNT_W          = 16,
  parameter bit ZERO_REG_GUARD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_stall,
  input  logic             in_flush,
  input  logic             in_Reg_Write_Ctrl,
  input  logic             in_Byte_Word,
  input  logic             in_Mem_Or_Reg,
  input  logic             in_Signed_Load,
  input  logic [31:0]      in_Alu_Result,
  input  logic [31:0]      in_Mem_Data,
  input  logic [4:0]       in_Dest_Reg,
  output logic             out_valid,
  output logic             out_Reg_Write_En,
  output logic [4:0]       out_Write_Reg,
  output logic [31:0]      out_Write_Data,
  output logic             out_Misaligned,
  output logic [CNT_W-1:0] out_Retire_Count
);

  logic             valid_q;
  logic             rw_q;
  logic             bw_q;
  logic             mor_q;
  logic             sgn_q;
  logic [31:0]      alu_q;
  logic [31:0]      mem_q;
  logic [4:0]       dest_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      bw_q    <= 1'b0;
      mor_q   <= 1'b0;
      sgn_q   <= 1'b0;
      alu_q   <= '0;
      mem_q   <= '0;
      dest_q  <= '0;
      cnt_q   <= '0;
    end else if (in_flush) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      bw_q    <= 1'b0;
      mor_q   <= 1'b0;
      sgn_q   <= 1'b0;
      alu_q   <= '0;
      mem_q   <= '0;
      dest_q  <= '0;
    end else if (!in_stall) begin
      valid_q <= in_valid;
      rw_q    <= in_Reg_Write_Ctrl;
      bw_q    <= in_Byte_Word;
      mor_q   <= in_Mem_Or_Reg;
      sgn_q   <= in_Signed_Load;
      alu_q   <= in_Alu_Result;
      mem_q   <= in_Mem_Data;
      dest_q  <= in_Dest_Reg;
      if (in_valid)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  logic [7:0]  byte_sel;
  logic [31:0] byte_ext;
  logic [31:0] wdata;
  logic        zero_dest;

  // Little-endian byte lane picked by the low address bits
  always_comb begin
    byte_sel = mem_q[7:0];
    case (alu_q[1:0])
      2'd0: byte_sel = mem_q[7:0];
      2'd1: byte_sel = mem_q[15:8];
      2'd2: byte_sel = mem_q[23:16];
      2'd3: byte_sel = mem_q[31:24];
      default: byte_sel = mem_q[7:0];
    endcase
    if (sgn_q)
      byte_ext = {{24{byte_sel[7]}}, byte_sel};
    else
      byte_ext = {24'b0, byte_sel};
  end

  always_comb begin
    wdata = alu_q;
    unique case (1'b1)
      !mor_q:         wdata = alu_q;
      mor_q && !bw_q: wdata = mem_q;
      default:        wdata = byte_ext;
    endcase
  end

  assign zero_dest = ZERO_REG_GUARD && (dest_q == 5'd0);

  assign out_valid        = valid_q;
  assign out_Reg_Write_En = valid_q & rw_q & ~zero_dest;
  assign out_Write_Reg    = dest_q;
  assign out_Write_Data   = wdata;
  assign out_Misaligned   = valid_q & mor_q & ~bw_q
                          & (alu_q[1:0] != 2'b00);
  assign out_Retire_Count = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// Directed bench for mem_wb_stage_reg: vector table plus
// reset, stall, flush and counter-wrap sequences.
module tb_mem_wb_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_stall, in_flush;
  logic        in_Reg_Write_Ctrl, in_Byte_Word;
  logic        in_Mem_Or_Reg, in_Signed_Load;
  logic [31:0] in_Alu_Result, in_Mem_Data;
  logic [4:0]  in_Dest_Reg;

  logic        out_valid, out_Reg_Write_En, out_Misaligned;
  logic [4:0]  out_Write_Reg;
  logic [31:0] out_Write_Data;
  logic [15:0] out_Retire_Count;

  logic        s_valid, s_en, s_mis;
  logic [4:0]  s_reg;
  logic [31:0] s_data;
  logic [3:0]  s_cnt;

  always #5 clk = ~clk;

  mem_wb_stage_reg u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_stall(in_stall), .in_flush(in_flush),
    .in_Reg_Write_Ctrl(in_Reg_Write_Ctrl), .in_Byte_Word(in_Byte_Word),
    .in_Mem_Or_Reg(in_Mem_Or_Reg), .in_Signed_Load(in_Signed_Load),
    .in_Alu_Result(in_Alu_Result), .in_Mem_Data(in_Mem_Data),
    .in_Dest_Reg(in_Dest_Reg),
    .out_valid(out_valid), .out_Reg_Write_En(out_Reg_Write_En),
    .out_Write_Reg(out_Write_Reg), .out_Write_Data(out_Write_Data),
    .out_Misaligned(out_Misaligned), .out_Retire_Count(out_Retire_Count)
  );

  // Narrow counter, guard disabled
  mem_wb_stage_reg #(.CNT_W(4), .ZERO_REG_GUARD(1'b0)) u_small (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_stall(in_stall), .in_flush(in_flush),
    .in_Reg_Write_Ctrl(in_Reg_Write_Ctrl), .in_Byte_Word(in_Byte_Word),
    .in_Mem_Or_Reg(in_Mem_Or_Reg), .in_Signed_Load(in_Signed_Load),
    .in_Alu_Result(in_Alu_Result), .in_Mem_Data(in_Mem_Data),
    .in_Dest_Reg(in_Dest_Reg),
    .out_valid(s_valid), .out_Reg_Write_En(s_en),
    .out_Write_Reg(s_reg), .out_Write_Data(s_data),
    .out_Misaligned(s_mis), .out_Retire_Count(s_cnt)
  );

  typedef struct {
    logic        v, rw, bw, mor, sgn;
    logic [31:0] alu, mem;
    logic [4:0]  dest;
    logic        en;
    logic [31:0] data;
    logic        mis;
  } vec_t;

  vec_t vecs[11];
  int checks = 0;
  int errors = 0;
  int cnt_model = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    in_valid          = x.v;
    in_Reg_Write_Ctrl = x.rw;
    in_Byte_Word      = x.bw;
    in_Mem_Or_Reg     = x.mor;
    in_Signed_Load    = x.sgn;
    in_Alu_Result     = x.alu;
    in_Mem_Data       = x.mem;
    in_Dest_Reg       = x.dest;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_en"},    {31'b0, out_Reg_Write_En}, 32'd0);
    chk({tag, "_reg"},   {27'b0, out_Write_Reg}, 32'd0);
    chk({tag, "_data"},  out_Write_Data, 32'd0);
    chk({tag, "_mis"},   {31'b0, out_Misaligned}, 32'd0);
  endtask

  initial begin
    vec_t hold;
    vec_t alt;
    // v rw bw mor sgn alu mem dest | en data mis
    vecs[0]  = '{1,1,1,1,1, 32'h0000_1003, 32'h80FF_1234, 5'd5,
                 1, 32'hFFFF_FF80, 0};
    vecs[1]  = '{1,1,1,1,0, 32'h0000_1003, 32'h80FF_1234, 5'd5,
                 1, 32'h0000_0080, 0};
    vecs[2]  = '{1,1,1,1,0, 32'h0000_1001, 32'h80FF_1234, 5'd5,
                 1, 32'h0000_0012, 0};
    vecs[3]  = '{1,1,0,0,0, 32'h1234_5678, 32'h0000_0000, 5'd0,
                 0, 32'h1234_5678, 0};
    vecs[4]  = '{1,1,0,0,0, 32'hDEAD_BEEF, 32'h0000_0000, 5'd7,
                 1, 32'hDEAD_BEEF, 0};
    vecs[5]  = '{1,1,0,1,0, 32'h0000_2000, 32'hCAFE_F00D, 5'd9,
                 1, 32'hCAFE_F00D, 0};
    vecs[6]  = '{1,1,0,1,0, 32'h0000_2002, 32'hCAFE_F00D, 5'd9,
                 1, 32'hCAFE_F00D, 1};
    vecs[7]  = '{0,1,0,1,0, 32'h0000_2001, 32'h1111_2222, 5'd3,
                 0, 32'h1111_2222, 0};
    vecs[8]  = '{1,1,1,1,1, 32'h0000_1000, 32'h0000_007F, 5'd4,
                 1, 32'h0000_007F, 0};
    vecs[9]  = '{1,1,1,1,1, 32'h0000_1002, 32'h00AB_0000, 5'd31,
                 1, 32'hFFFF_FFAB, 0};
    vecs[10] = '{1,1,1,0,1, 32'h0000_0083, 32'hFFFF_FFFF, 5'd2,
                 1, 32'h0000_0083, 0};

    rst = 1'b1;
    in_stall = 1'b0;
    in_flush = 1'b0;
    drive(vecs[0]);
    #1;
    chk_zero("reset");
    chk("reset_cnt", {16'b0, out_Retire_Count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table: one load per vector, latency one edge
    foreach (vecs[i]) begin
      drive(vecs[i]);
      tick();
      if (vecs[i].v) cnt_model++;
      chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].v});
      chk($sformatf("v%0d_en", i), {31'b0, out_Reg_Write_En},
          {31'b0, vecs[i].en});
      chk($sformatf("v%0d_reg", i), {27'b0, out_Write_Reg},
          {27'b0, vecs[i].dest});
      chk($sformatf("v%0d_data", i), out_Write_Data, vecs[i].data);
      chk($sformatf("v%0d_mis", i), {31'b0, out_Misaligned},
          {31'b0, vecs[i].mis});
      chk($sformatf("v%0d_cnt", i), {16'b0, out_Retire_Count}, cnt_model);
    end

    // Guard disabled: dest 0 write goes through
    drive(vecs[3]);
    tick();
    cnt_model++;
    chk("noguard_en", {31'b0, s_en}, 32'd1);
    chk("guard_en", {31'b0, out_Reg_Write_En}, 32'd0);

    // Stall 3 cycles with changing inputs
    drive(vecs[4]);
    tick();
    cnt_model++;
    in_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(vecs[k]);
      tick();
      chk($sformatf("stall%0d_data", k), out_Write_Data, 32'hDEAD_BEEF);
      chk($sformatf("stall%0d_reg", k), {27'b0, out_Write_Reg}, 32'd7);
      chk($sformatf("stall%0d_en", k), {31'b0, out_Reg_Write_En}, 32'd1);
      chk($sformatf("stall%0d_cnt", k), {16'b0, out_Retire_Count},
          cnt_model);
    end

    // Stall and flush on the same edge: flush wins
    in_flush = 1'b1;
    tick();
    chk_zero("flush");
    chk("flush_cnt", {16'b0, out_Retire_Count}, cnt_model);
    in_flush = 1'b0;
    in_stall = 1'b0;

    // Async reset mid-cycle while WB holds a valid instruction
    drive(vecs[4]);
    tick();
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    chk("midrst_cnt", {16'b0, out_Retire_Count}, 32'd0);
    chk("midrst_cnt4", {28'b0, s_cnt}, 32'd0);
    #1;
    rst = 1'b0;
    tick();
    chk("post_rst_cnt", {16'b0, out_Retire_Count}, 32'd1);
    chk("post_rst_data", out_Write_Data, 32'hDEAD_BEEF);

    // Narrow counter wrap: restart from 0, 16 valid loads
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    hold = vecs[4];
    for (int k = 1; k <= 16; k++) begin
      drive(hold);
      tick();
      if (k == 15)
        chk("cnt4_15", {28'b0, s_cnt}, 32'd15);
    end
    chk("cnt4_wrap", {28'b0, s_cnt}, 32'd0);
    chk("cnt16_16", {16'b0, out_Retire_Count}, 32'd16);

    // Invalid loads do not count
    alt = vecs[7];
    drive(alt);
    tick();
    chk("inval_cnt4", {28'b0, s_cnt}, 32'd0);
    chk("inval_cnt16", {16'b0, out_Retire_Count}, 32'd16);

    // Misaligned word load on the narrow instance
    drive(vecs[6]);
    tick();
    chk("lw_mis", {31'b0, s_mis}, 32'd1);
    chk("lw_mis_data", s_data, 32'hCAFE_F00D);
    chk("lw_mis_cnt4", {28'b0, s_cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
